result_serializer: RTL

- Output stage of the matrix-multiply core. Sits between the systolic-array accumulator output and the single-bit out_valid/out_value pads.
- Buffers parallel result words in a small FIFO.
- Emits each word bit-serially as a LEN_W-bit length field followed by the value with leading zeros stripped, MSB first.
- Lets the array run ahead of the slow serial output.

---
 rtl/result_serializer_if.sv | 24 ++
 rtl/result_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/result_serializer_if.sv
// Handshake and serial-output bundle for result_serializer.
// The slave modport is the serializer; the master modport is the result source / pad side.
interface result_serializer_if #(
  parameter int DATA_W = 40
) ();
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              res_ready;
  logic              out_valid;
  logic              out_value;
  logic              done;
  logic              busy;

  modport master (
    output res_valid, res_data, res_last,
    input  res_ready, out_valid, out_value, done, busy
  );

  modport slave (
    input  res_valid, res_data, res_last,
    output res_ready, out_valid, out_value, done, busy
  );
endinterface

// File: rtl/result_serializer.sv
// Buffers result words in a small FIFO and emits each as a LEN_W-bit length then the
// zero-stripped value, MSB first. Define RESULT_PARITY_EN to append an even-parity bit.
//   state  | meaning
//   S_IDLE | output quiet, waiting for a buffered word
//   S_LEN  | shifting out the length field
//   S_VAL  | shifting out value[len-1:0]
//   S_PAR  | parity bit (RESULT_PARITY_EN only)
module result_serializer #(
  parameter int DATA_W     = 40,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  result_serializer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef RESULT_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_VAL, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_VAL} state_t;
`endif

  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  logic [DATA_W-1:0] r_val_sh;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_len_sh;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_last;
`ifdef RESULT_PARITY_EN
  logic              r_par;
`endif
  logic              r_out_valid;
  logic              r_out_value;
  logic              r_done_pend;
  logic              r_done;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_last_bit;
  logic [DATA_W:0]   w_head;
  logic [DATA_W-1:0] w_head_data;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_shift;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.res_valid && !w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_data = w_head[DATA_W-1:0];

`ifdef RESULT_PARITY_EN
  assign w_last_bit = (r_state == S_PAR);
`else
  assign w_last_bit = (r_state == S_VAL) && (r_cnt == '0);
`endif
  // The next word is popped on the final bit so the stream continues without a gap.
  assign w_pop = !w_empty && ((r_state == S_IDLE) || w_last_bit);

  always_comb begin
    w_len = LEN_W'(1);
    for (int i = 0; i < DATA_W; i++) begin
      if (w_head_data[i]) w_len = LEN_W'(i + 1);
    end
  end

  // Left-align the value so its top significant bit sits at the shifter MSB.
  assign w_shift = LEN_W'(DATA_W) - w_len;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.res_last, bus.res_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_val_sh    <= '0;
      r_len       <= '0;
      r_len_sh    <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
`ifdef RESULT_PARITY_EN
      r_par       <= 1'b0;
`endif
      r_out_valid <= 1'b0;
      r_out_value <= 1'b0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          r_out_value <= 1'b0;
        end
        S_LEN: begin
          r_out_valid <= 1'b1;
          r_out_value <= r_len_sh[LEN_W-1];
          r_len_sh    <= r_len_sh << 1;
          if (r_cnt == '0) begin
            r_state <= S_VAL;
            r_cnt   <= r_len - 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_VAL: begin
          r_out_valid <= 1'b1;
          r_out_value <= r_val_sh[DATA_W-1];
          r_val_sh    <= r_val_sh << 1;
          r_cnt       <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
`ifdef RESULT_PARITY_EN
            r_state <= S_PAR;
`else
            r_state     <= S_IDLE;
            r_done_pend <= r_last;
`endif
          end
        end
`ifdef RESULT_PARITY_EN
        S_PAR: begin
          r_out_valid <= 1'b1;
          r_out_value <= r_par;
          r_state     <= S_IDLE;
          r_done_pend <= r_last;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
      // A pop overrides the IDLE return above; r_done_pend already used the old r_last.
      if (w_pop) begin
        r_state  <= S_LEN;
        r_cnt    <= LEN_W'(LEN_W - 1);
        r_len    <= w_len;
        r_len_sh <= w_len;
        r_val_sh <= w_head_data << w_shift;
        r_last   <= w_head[DATA_W];
`ifdef RESULT_PARITY_EN
        r_par    <= ^w_head_data;
`endif
      end
    end
  end

  assign bus.res_ready = !w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign bus.done      = r_done;
  assign bus.busy      = !w_empty || (r_state != S_IDLE) || r_out_valid;

endmodule
